grid_ws2812_driver: RTL and testbench
=====================================

Name: grid_ws2812_driver

Overview:
- Downstream consumer of the 8x8 life-grid generator. Takes its 64-bit grid snapshot and serialises it onto a single WS2812 (NeoPixel) data line, one 24-bit GRB word per LED, LED 0 first.
- Each frame is followed by a latch (reset-low) interval.
- Grid is shadow-captured at frame start, so generator updates mid-frame never tear the display.

Parameters:
- BIT_CYCLES, 15: clocks per WS2812 bit period (1.25 us at 12 MHz).
- T0H_CYCLES, 5: high time for a 0 bit.
- T1H_CYCLES, 10: high time for a 1 bit.
- RESET_CYCLES, 3600: low time after the last bit (300 us at 12 MHz).
- ON_COLOR, 24'h00_20_00: GRB word for a live cell.
- OFF_COLOR, 24'h00_00_00: GRB word for a dead cell.
- SERPENTINE, 0: 1 = odd rows are wired right-to-left.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a frame; sampled only when busy=0
- grid_in  input  64  cell bits, index = row*8+col, 1 = live
- data_out  output  1  WS2812 serial line
- busy  output  1  high from accepted start until latch interval ends
- frame_done  output  1  one-cycle pulse when the latch interval completes

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE, data_out=0, busy=0, frame_done=0, counters 0, shadow grid 0.
- States: IDLE, SEND, LATCH.
- IDLE:
  - data_out=0.
  - If start=1: capture shadow<=grid_in, led_idx<=0, bit_idx<=23, cyc<=0, go to SEND.
  - busy=1 and data_out=1 from the next cycle on (1-cycle start-to-first-edge latency).
- SEND:
  - Current bit b = color[bit_idx], where color = ON_COLOR if cell(led_idx) else OFF_COLOR.
  - Bit order is MSB first: G7..G0, R7..R0, B7..B0.
  - data_out=1 while cyc < (b ? T1H_CYCLES : T0H_CYCLES), else 0.
  - cyc counts 0..BIT_CYCLES-1. At BIT_CYCLES-1: cyc<=0, then bit_idx decrements. After bit_idx=0: bit_idx<=23, led_idx increments.
  - After led 63 bit 0 completes, go to LATCH with cyc<=0.
- Cell mapping:
  - p=led_idx, r=p[5:3], c=p[2:0].
  - Cell index = p, except when SERPENTINE=1 and r odd: r*8+(7-c).
- LATCH:
  - data_out=0 for RESET_CYCLES clocks, then go to IDLE.
  - In the first IDLE cycle: frame_done=1 and busy=0.
- Frame length: 1536*BIT_CYCLES + RESET_CYCLES clocks, from the first data_out rise to frame_done. Defaults give 26640.
- start while busy=1: ignored, no queuing.
- start in the frame_done cycle: accepted (state is IDLE).
- Shadow is written only on an accepted start. grid_in changes during SEND/LATCH have no effect.
- rst mid-frame: next edge gives IDLE, data_out=0, busy=0, no frame_done. LEDs see the long low as a latch, so a partial frame is harmless.
- Counter widths:
  - cyc: $clog2(max(BIT_CYCLES, RESET_CYCLES)) bits.
  - led_idx: 6 bits.
  - bit_idx: 5 bits.
  - No wrap except as stated above.
- Elaboration check: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES, and RESET_CYCLES >= 1. Violation is a fatal error.
- Outputs are registered: data_out, busy and frame_done all come from flops.

Decomposition:
- Package ws2812_pkg:
  - state enum {IDLE, SEND, LATCH}.
  - Default timing constants for 12 MHz.
  - Color constants (GRB_OFF, GRB_DIM_GREEN).
  - Function led_to_cell(p, serpentine).
- Sub-module ws2812_bit_encoder:
  - Inputs: clk, rst, bit_valid, bit_val.
  - Outputs: data_out, bit_ready (pulse at end of period).
  - Owns cyc and T0H/T1H/BIT_CYCLES timing.
- Top FSM owns the shadow grid, the led/bit counters and LATCH timing.

Test Plan:
- Reset, then idle 100 cycles: data_out=0, busy=0, frame_done=0 throughout. start during rst is ignored.
- grid_in=64'h1, pulse start:
  - data_out rises 1 cycle later.
  - LED 0 gives 24 pulses: bits 23..16 (G=0x20) show one 10-cycle pulse at bit 21, the rest 5-cycle; R and B are all 5-cycle.
  - LEDs 1..63 are all 5-cycle pulses.
  - frame_done fires exactly 26640 cycles after the first rise.
- grid_in=64'hFFFF_FFFF_FFFF_FFFF; toggle grid_in to 0 at cycle 500:
  - Decoded stream still shows all 64 LEDs = ON_COLOR.
- start held high continuously:
  - Back-to-back frames, each start accepted in the frame_done cycle.
  - busy low exactly 1 cycle between frames.
- Assert rst at cycle 8000 of a frame:
  - Next cycle data_out=0, busy=0, no frame_done.
  - A new start then produces a full correct frame.
- SERPENTINE=1, grid_in=64'h0000_0000_0000_0100 (cell 8 = row1 col0):
  - Decoded ON_COLOR appears at LED 15.
  - All others are OFF_COLOR.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types, default 12 MHz timing, colours and LED-to-cell mapping for the
// grid WS2812 driver.
package ws2812_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StLatch
  } state_e;

  // Defaults assume a 12 MHz clock: 1.25 us bit period, 300 us latch.
  localparam int unsigned DEF_BIT_CYCLES   = 15;
  localparam int unsigned DEF_T0H_CYCLES   = 5;
  localparam int unsigned DEF_T1H_CYCLES   = 10;
  localparam int unsigned DEF_RESET_CYCLES = 3600;

  // GRB order, green in the top byte.
  localparam logic [23:0] GRB_OFF       = 24'h00_00_00;
  localparam logic [23:0] GRB_DIM_GREEN = 24'h00_20_00;

  localparam int unsigned NUM_LEDS     = 64;
  localparam int unsigned BITS_PER_LED = 24;

  // Map a position on the LED chain to a grid cell; serpentine chains run odd
  // rows right-to-left.
  function automatic logic [5:0] led_to_cell(input logic [5:0] p, input logic serpentine);
    logic [2:0] r;
    logic [2:0] c;
    r = p[5:3];
    c = p[2:0];
    if (serpentine && r[0]) begin
      return {r, 3'd7 - c};
    end
    return p;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Turns a stream of bits into WS2812 pulses: every bit occupies BIT_CYCLES clocks
// and is high for T0H_CYCLES (0) or T1H_CYCLES (1). The output is registered.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int unsigned T1H_CYCLES = DEF_T1H_CYCLES,
  parameter int unsigned CYC_W      = $clog2(DEF_BIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_val,
  output logic data_out,
  output logic bit_ready
);

  localparam logic [CYC_W-1:0] LastCyc = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] T0hCyc  = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1hCyc  = CYC_W'(T1H_CYCLES);

  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             active_q, active_d;
  logic             cur_bit_q, cur_bit_d;
  logic             data_q, data_d;

  // Last clock of the current period; the caller presents the next bit here.
  assign bit_ready = active_q && (cyc_q == LastCyc);
  assign data_out  = data_q;

  // Load a new bit when idle or at the end of a period, otherwise keep counting.
  // data_d looks at next-state values so data_out lines up with cyc without lag.
  always_comb begin
    cyc_d     = cyc_q;
    active_d  = active_q;
    cur_bit_d = cur_bit_q;
    if (!active_q || bit_ready) begin
      cyc_d    = '0;
      active_d = bit_valid;
      if (bit_valid) begin
        cur_bit_d = bit_val;
      end
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
    data_d = active_d && (cyc_d < (cur_bit_d ? T1hCyc : T0hCyc));
  end

  // Bit timing state and registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      active_q  <= 1'b0;
      cur_bit_q <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      cyc_q     <= cyc_d;
      active_q  <= active_d;
      cur_bit_q <= cur_bit_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: rtl/grid_ws2812_driver.sv
// Serialises an 8x8 life grid onto a WS2812 chain, LED 0 first, one GRB word per
// LED, followed by a latch interval. The grid is shadowed at frame start so
// upstream updates never tear a frame.
module grid_ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int unsigned T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int unsigned T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter logic [23:0] ON_COLOR     = GRB_DIM_GREEN,
  parameter logic [23:0] OFF_COLOR    = GRB_OFF,
  parameter bit          SERPENTINE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] grid_in,
  output logic        data_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned MaxCycles = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int unsigned CycW      = $clog2(MaxCycles);
  localparam logic [CycW-1:0] LatchLast = CycW'(RESET_CYCLES - 1);

  // Refuse to build with timing that cannot produce distinguishable pulses.
  if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES) &&
        (RESET_CYCLES >= 1))) begin : g_bad_timing
    $fatal(1, "grid_ws2812_driver: illegal timing parameters");
  end

  state_e          state_q, state_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [5:0]      led_q, led_d;
  logic [4:0]      bit_q, bit_d;
  logic [CycW-1:0] latch_q, latch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            bit_valid;
  logic            bit_val;
  logic            bit_ready;
  logic [23:0]     color;

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES),
    .CYC_W      (CycW)
  ) u_encoder (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_val   (bit_val),
    .data_out  (data_out),
    .bit_ready (bit_ready)
  );

  assign busy       = busy_q;
  assign frame_done = done_q;

  // State, shadow grid, LED/bit counters, latch timer and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      led_q    <= '0;
      bit_q    <= '0;
      latch_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      led_q    <= led_d;
      bit_q    <= bit_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Frame sequencing: capture on start, walk 64 LEDs x 24 bits, then latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    led_d    = led_q;
    bit_d    = bit_q;
    latch_d  = latch_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = grid_in;
          led_d    = '0;
          bit_d    = 5'(BITS_PER_LED - 1);
          latch_d  = '0;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (bit_ready) begin
          if (bit_q == '0) begin
            bit_d = 5'(BITS_PER_LED - 1);
            if (led_q == 6'(NUM_LEDS - 1)) begin
              latch_d = '0;
              state_d = StLatch;
            end else begin
              led_d = led_q + 6'd1;
            end
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end
      end
      StLatch: begin
        if (latch_q == LatchLast) begin
          state_d = StIdle;
        end else begin
          latch_d = latch_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next bit for the encoder (from next-state counters) and registered flags.
  always_comb begin
    color     = shadow_d[led_to_cell(led_d, SERPENTINE)] ? ON_COLOR : OFF_COLOR;
    bit_val   = color[bit_d];
    bit_valid = (state_d == StSend);
    busy_d    = (state_d != StIdle);
    done_d    = (state_q == StLatch) && (state_d == StIdle);
  end

endmodule

// File: tb/tb_grid_ws2812_driver.sv
// Bench for grid_ws2812_driver: two instances (default timing, and a short-timing
// serpentine one). Stimulus pushes expected GRB words; a monitor decodes the
// serial line and pops/compares each completed word.
module tb_grid_ws2812_driver;

  localparam int unsigned A_BIT   = 15;
  localparam int unsigned A_T0H   = 5;
  localparam int unsigned A_T1H   = 10;
  localparam int unsigned A_FRAME = 26640;
  localparam logic [23:0] A_ON    = 24'h00_20_00;
  localparam logic [23:0] A_OFF   = 24'h00_00_00;

  localparam int unsigned S_BIT   = 6;
  localparam int unsigned S_T0H   = 2;
  localparam int unsigned S_T1H   = 4;
  localparam int unsigned S_RST   = 20;
  localparam int unsigned S_FRAME = 9236;
  localparam logic [23:0] S_ON    = 24'hA5_5A_C3;
  localparam logic [23:0] S_OFF   = 24'h01_02_03;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_start = 1'b0;
  logic        s_start = 1'b0;
  logic [63:0] a_grid = '0;
  logic [63:0] s_grid = '0;
  logic        a_data, a_busy, a_done;
  logic        s_data, s_busy, s_done;

  int unsigned cycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_a[$];
  logic [23:0] exp_s[$];

  grid_ws2812_driver u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (a_start),
    .grid_in    (a_grid),
    .data_out   (a_data),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  grid_ws2812_driver #(
    .BIT_CYCLES   (S_BIT),
    .T0H_CYCLES   (S_T0H),
    .T1H_CYCLES   (S_T1H),
    .RESET_CYCLES (S_RST),
    .ON_COLOR     (S_ON),
    .OFF_COLOR    (S_OFF),
    .SERPENTINE   (1'b1)
  ) u_dut_s (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .grid_in    (s_grid),
    .data_out   (s_data),
    .busy       (s_busy),
    .frame_done (s_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic wait_done(input bit ch, input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((ch ? s_done : a_done) !== 1'b1) && (n < budget));
    check(name, ch ? s_done : a_done, 1);
  endtask

  initial begin : watchdog
    #(10 * 80000);
    $display("FAIL watchdog: run exceeded 80000 cycles");
    $fatal(1, "watchdog expired");
  end

  // Decoder/scoreboard state, one slot per instance.
  bit          prev[2], in_frame[2], seen[2];
  int          hi[2], since[2], nbits[2], led[2];
  int unsigned t0[2];
  logic [23:0] word[2];

  initial begin : monitor
    logic        d, b, f, bv;
    int          w, t0h, t1h, per, flen, qsz;
    logic [23:0] exp_w;
    for (int ch = 0; ch < 2; ch++) begin
      prev[ch] = 0; in_frame[ch] = 0; seen[ch] = 0;
      hi[ch] = 0; since[ch] = 0; nbits[ch] = 0; led[ch] = 0; t0[ch] = 0; word[ch] = '0;
    end
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        d    = ch ? s_data : a_data;
        b    = ch ? s_busy : a_busy;
        f    = ch ? s_done : a_done;
        t0h  = ch ? S_T0H : A_T0H;
        t1h  = ch ? S_T1H : A_T1H;
        per  = ch ? S_BIT : A_BIT;
        flen = ch ? S_FRAME : A_FRAME;
        if (rst) begin
          if (in_frame[ch]) begin
            if (ch == 0) exp_a.delete();
            else exp_s.delete();
          end
          in_frame[ch] = 0; prev[ch] = 0; seen[ch] = 0;
          hi[ch] = 0; since[ch] = 0; nbits[ch] = 0; led[ch] = 0;
        end else begin
          if (b && !in_frame[ch]) begin
            in_frame[ch] = 1; t0[ch] = cycle; seen[ch] = 0;
            hi[ch] = 0; nbits[ch] = 0; led[ch] = 0;
            check($sformatf("ch%0d first edge with busy", ch), d, 1);
          end
          since[ch]++;
          if (d && !prev[ch]) begin
            if (seen[ch]) check($sformatf("ch%0d bit period", ch), since[ch], per);
            since[ch] = 0;
            seen[ch]  = 1;
          end
          if (d) begin
            hi[ch]++;
          end else if (prev[ch]) begin
            w = hi[ch];
            hi[ch] = 0;
            if (w == t1h) begin
              bv = 1'b1;
            end else begin
              if (w != t0h) check($sformatf("ch%0d pulse width", ch), w, t0h);
              bv = 1'b0;
            end
            word[ch] = {word[ch][22:0], bv};
            nbits[ch]++;
            if (nbits[ch] == 24) begin
              qsz = (ch == 0) ? exp_a.size() : exp_s.size();
              if (qsz == 0) begin
                check($sformatf("ch%0d expected word queued", ch), qsz, 1);
              end else begin
                exp_w = (ch == 0) ? exp_a.pop_front() : exp_s.pop_front();
                check($sformatf("ch%0d led %0d word", ch, led[ch]), word[ch], exp_w);
              end
              led[ch]++;
              nbits[ch] = 0;
            end
          end
          if (f) begin
            check($sformatf("ch%0d done inside frame", ch), in_frame[ch], 1);
            check($sformatf("ch%0d frame length", ch), cycle - t0[ch], flen);
            check($sformatf("ch%0d busy low at done", ch), b, 0);
            check($sformatf("ch%0d line low at done", ch), d, 0);
            check($sformatf("ch%0d leds in frame", ch), led[ch], 64);
            in_frame[ch] = 0;
          end
          prev[ch] = d;
        end
      end
    end
  end

  initial begin : stimulus
    logic [63:0] gb;
    // Reset with start held high: it must be ignored.
    rst = 1'b1; a_start = 1'b1; s_start = 1'b1; a_grid = '1; s_grid = '1;
    repeat (4) begin
      @(negedge clk);
      check("busy during rst", a_busy, 0);
      check("serp busy during rst", s_busy, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_start = 1'b0; s_start = 1'b0;

    fork
      begin : chain_a
        repeat (100) begin
          @(negedge clk);
          check("idle data_out", a_data, 0);
          check("idle busy", a_busy, 0);
          check("idle frame_done", a_done, 0);
        end
        // Frame A: only cell 0 live; start stays high for a back-to-back frame B.
        a_grid = 64'h1;
        for (int i = 0; i < 64; i++) exp_a.push_back((i == 0) ? A_ON : A_OFF);
        @(posedge clk); #1 a_start = 1'b1;
        @(negedge clk);
        check("no edge before capture", a_data, 0);
        @(negedge clk);
        check("first edge one cycle after start", a_data, 1);
        check("busy after start", a_busy, 1);
        gb = 64'hF0F0_0F0F_AAAA_5555;
        a_grid = gb;
        for (int i = 0; i < 64; i++) exp_a.push_back(gb[i] ? A_ON : A_OFF);
        wait_done(0, A_FRAME + 5, "frame A done");
        check("busy gap at done", a_busy, 0);
        @(negedge clk);
        check("frame B accepted busy", a_busy, 1);
        check("frame B first edge", a_data, 1);
        a_start = 1'b0;
        // Reset about 8000 cycles into frame B.
        repeat (7998) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst data_out", a_data, 0);
        check("rst busy", a_busy, 0);
        check("rst frame_done", a_done, 0);
        repeat (2) begin
          @(negedge clk);
          check("rst held frame_done", a_done, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) begin
          @(negedge clk);
          check("post-rst frame_done", a_done, 0);
          check("post-rst busy", a_busy, 0);
        end
        // Frame D: all live, grid cleared 500 cycles in must not matter.
        a_grid = '1;
        for (int i = 0; i < 64; i++) exp_a.push_back(A_ON);
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        repeat (499) @(posedge clk);
        #1 a_grid = '0;
        wait_done(0, A_FRAME, "frame D done");
        @(negedge clk);
        check("frame_done one cycle", a_done, 0);
        check("idle after frame D", a_busy, 0);
      end
      begin : chain_s
        repeat (50) @(negedge clk);
        // Cell 8 (row 1 col 0) sits at LED 15 on a serpentine chain.
        s_grid = 64'h0000_0000_0000_0100;
        for (int i = 0; i < 64; i++) exp_s.push_back((i == 15) ? S_ON : S_OFF);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        wait_done(1, S_FRAME + 5, "serp frame 1 done");
        // Cells 0, 15, 16 map to LEDs 0, 8, 16.
        s_grid = 64'h0000_0000_0001_8001;
        for (int i = 0; i < 64; i++) exp_s.push_back((i == 0 || i == 8 || i == 16) ? S_ON : S_OFF);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        wait_done(1, S_FRAME + 5, "serp frame 2 done");
      end
    join

    repeat (5) @(negedge clk);
    check("leftover words ch0", exp_a.size(), 0);
    check("leftover words ch1", exp_s.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
